viterbi_channel_harness: RTL and testbench

Parametrised channel stage that sits between the convolutional encoder and the Viterbi decoder. It injects errors into each W-bit code word in one of four selectable modes: none, periodic, burst or LFSR-random. It counts the bit errors it injects. It also checks the decoder output against a FIFO of original input bits and counts decoded bit errors, so coding gain is measured in hardware.

---
 rtl/viterbi_channel_harness.sv | 154 +++++++++++++++
 tb/tb_viterbi_channel_harness.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_channel_harness.sv
// Channel stage between convolutional encoder and Viterbi decoder: injects code word
// errors in one of four modes and scores decoded bits against a FIFO of reference bits.
module viterbi_channel_harness #(
   parameter int          W      = 2,
   parameter int          N      = 3,
   parameter int          WINDOW = 256,
   parameter int          DEPTH  = 64,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   mode_i,
   input  logic [W-1:0] err_mask_i,
   input  logic [7:0]   ber_thresh_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         ref_bit_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   input  logic         dec_valid_i,
   input  logic         dec_bit_i,
   output logic [15:0]  word_count_o,
   output logic [15:0]  inj_count_o,
   output logic [15:0]  dec_err_count_o,
   output logic         overflow_o,
   output logic         underflow_o,
   output logic         done_o
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [16:0] WINDOW_L = 17'(WINDOW);
   localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);

   logic [15:0]   lfsr;
   logic [15:0]   lfsr_nxt;
   logic          fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic [AW:0]   cnt_nxt;

   logic          inject;
   logic          in_window;
   logic          fifo_empty;
   logic          fifo_full;
   logic          do_push;
   logic          do_pop;
   logic          mismatch;
   logic [15:0]   word_nxt;
   logic [15:0]   inj_nxt;
   logic [15:0]   err_nxt;
   logic [16:0]   inj_sum;

   function automatic logic [15:0] popcount(input logic [W-1:0] v);
      logic [15:0] c;
      c = '0;
      for (int i = 0; i < W; i++) begin
         c = c + 16'(v[i]);
      end
      return c;
   endfunction

   // Injection decision uses the pre-increment word count and the pre-advance LFSR.
   always_comb begin
      inject    = 1'b0;
      in_window = ({1'b0, word_count_o} < WINDOW_L);
      case (mode_i)
         2'd1:    inject = in_window && (word_count_o[N-1:0] == {N{1'b1}});
         2'd2:    inject = in_window && word_count_o[N];
         2'd3:    inject = (lfsr[7:0] < ber_thresh_i);
         default: inject = 1'b0;
      endcase
   end

   always_comb begin
      lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      fifo_empty = (fifo_cnt == '0);
      fifo_full  = (fifo_cnt == DEPTH_L);
      do_pop     = dec_valid_i && !fifo_empty;
      do_push    = valid_i && (!fifo_full || do_pop);
      mismatch   = do_pop && (fifo_mem[rd_ptr] != dec_bit_i);

      cnt_nxt = fifo_cnt;
      if (do_push && !do_pop) begin
         cnt_nxt = fifo_cnt + 1'b1;
      end else if (do_pop && !do_push) begin
         cnt_nxt = fifo_cnt - 1'b1;
      end

      word_nxt = word_count_o;
      if (valid_i && (word_count_o != 16'hFFFF)) begin
         word_nxt = word_count_o + 16'd1;
      end

      inj_sum = {1'b0, inj_count_o} + {1'b0, popcount(err_mask_i)};
      inj_nxt = inj_count_o;
      if (valid_i && inject) begin
         inj_nxt = inj_sum[16] ? 16'hFFFF : inj_sum[15:0];
      end

      err_nxt = dec_err_count_o;
      if (mismatch && (dec_err_count_o != 16'hFFFF)) begin
         err_nxt = dec_err_count_o + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr            <= SEED;
         valid_o         <= 1'b0;
         data_o          <= '0;
         word_count_o    <= '0;
         inj_count_o     <= '0;
         dec_err_count_o <= '0;
         overflow_o      <= 1'b0;
         underflow_o     <= 1'b0;
         done_o          <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_cnt        <= '0;
      end else begin
         valid_o         <= valid_i;
         data_o          <= data_i ^ ((valid_i && inject) ? err_mask_i : '0);
         word_count_o    <= word_nxt;
         inj_count_o     <= inj_nxt;
         dec_err_count_o <= err_nxt;
         fifo_cnt        <= cnt_nxt;
         done_o          <= ({1'b0, word_nxt} >= WINDOW_L) && (cnt_nxt == '0);
         if (valid_i) begin
            lfsr <= lfsr_nxt;
         end
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (valid_i && fifo_full && !do_pop) begin
            overflow_o <= 1'b1;
         end
         if (dec_valid_i && fifo_empty) begin
            underflow_o <= 1'b1;
         end
      end
   end

   // Storage carries no reset; the pointers and occupancy define its contents.
   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         fifo_mem[wr_ptr] <= ref_bit_i;
      end
   end

endmodule

// File: tb/tb_viterbi_channel_harness.sv
// Self-checking bench for viterbi_channel_harness: a queue/arithmetic reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_viterbi_channel_harness;

   localparam int          W      = 2;
   localparam int          N      = 3;
   localparam int          WINDOW = 256;
   localparam int          DEPTH  = 64;
   localparam logic [15:0] SEED   = 16'hACE1;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   mode_i;
   logic [W-1:0] err_mask_i;
   logic [7:0]   ber_thresh_i;
   logic         valid_i;
   logic [W-1:0] data_i;
   logic         ref_bit_i;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         dec_valid_i;
   logic         dec_bit_i;
   logic [15:0]  word_count_o;
   logic [15:0]  inj_count_o;
   logic [15:0]  dec_err_count_o;
   logic         overflow_o;
   logic         underflow_o;
   logic         done_o;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   viterbi_channel_harness #(
      .W(W), .N(N), .WINDOW(WINDOW), .DEPTH(DEPTH), .SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .mode_i(mode_i), .err_mask_i(err_mask_i),
      .ber_thresh_i(ber_thresh_i), .valid_i(valid_i), .data_i(data_i),
      .ref_bit_i(ref_bit_i), .valid_o(valid_o), .data_o(data_o),
      .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
      .word_count_o(word_count_o), .inj_count_o(inj_count_o),
      .dec_err_count_o(dec_err_count_o), .overflow_o(overflow_o),
      .underflow_o(underflow_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   // Reference model state
   int           m_words, m_inj, m_err, mk;
   bit           m_ovf, m_unf, m_done, m_valid, minj, mb;
   logic [W-1:0] m_data;
   logic [15:0]  m_lfsr;
   bit           m_q[$];

   always @(posedge clk) begin
      if (rst) begin
         m_words = 0; m_inj = 0; m_err = 0;
         m_ovf = 0; m_unf = 0; m_done = 0; m_valid = 0;
         m_data = '0; m_lfsr = SEED;
         m_q.delete();
      end else begin
         mk = m_words;
         case (mode_i)
            2'd1:    minj = (mk < WINDOW) && ((mk % (1 << N)) == (1 << N) - 1);
            2'd2:    minj = (mk < WINDOW) && (((mk / (1 << N)) % 2) == 1);
            2'd3:    minj = (int'(m_lfsr) % 256) < int'(ber_thresh_i);
            default: minj = 1'b0;
         endcase
         m_valid = valid_i;
         m_data  = data_i ^ (minj ? err_mask_i : '0);
         if (valid_i) begin
            if (minj) m_inj = (m_inj + $countones(err_mask_i) > 65535) ? 65535 : m_inj + $countones(err_mask_i);
            m_words = (m_words < 65535) ? m_words + 1 : 65535;
            m_lfsr  = 16'({m_lfsr, ^(m_lfsr & 16'hB400)});
         end
         if (dec_valid_i) begin
            if (m_q.size() == 0) begin
               m_unf = 1'b1;
            end else begin
               mb = m_q.pop_front();
               if (mb != dec_bit_i && m_err < 65535) m_err = m_err + 1;
            end
         end
         if (valid_i) begin
            if (m_q.size() < DEPTH) m_q.push_back(ref_bit_i);
            else m_ovf = 1'b1;
         end
         m_done = (m_words >= WINDOW) && (m_q.size() == 0);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         checkOutput("valid_o", 32'(valid_o), 32'(m_valid));
         if (m_valid) checkOutput("data_o", 32'(data_o), 32'(m_data));
         checkOutput("word_count_o", 32'(word_count_o), m_words);
         checkOutput("inj_count_o", 32'(inj_count_o), m_inj);
         checkOutput("dec_err_count_o", 32'(dec_err_count_o), m_err);
         checkOutput("overflow_o", 32'(overflow_o), 32'(m_ovf));
         checkOutput("underflow_o", 32'(underflow_o), 32'(m_unf));
         checkOutput("done_o", 32'(done_o), 32'(m_done));
      end
   end

   task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit r, input bit dv, input bit db);
      @(negedge clk);
      valid_i = v; data_i = d; ref_bit_i = r; dec_valid_i = dv; dec_bit_i = db;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; valid_i = 0; data_i = '0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   bit refs [256];

   initial begin
      rst = 1'b1; mode_i = 2'd0; err_mask_i = '0; ber_thresh_i = 8'd0;
      valid_i = 0; data_i = '0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checking = 1'b1;
      checkOutput("reset_word_count", 32'(word_count_o), 0);
      checkOutput("reset_valid_o", 32'(valid_o), 0);

      // Periodic: one corrupted word in eight within the window
      mode_i = 2'd1; err_mask_i = 2'b10;
      for (int i = 0; i < 256; i++) applyStimulus(1'b1, 2'b00, 1'($urandom), 1'b0, 1'b0);
      idle();
      checkOutput("periodic_inj_count", 32'(inj_count_o), 32);
      checkOutput("periodic_word_count", 32'(word_count_o), 256);

      // Reset mid-run drops the in-flight word and restarts the pattern
      doReset();
      mode_i = 2'd1; err_mask_i = 2'b10;
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1; valid_i = 1'b1;
      @(negedge clk);
      rst = 1'b0; valid_i = 1'b0;
      checkOutput("midreset_word_count", 32'(word_count_o), 0);
      checkOutput("midreset_inj_count", 32'(inj_count_o), 0);
      checkOutput("midreset_valid_o", 32'(valid_o), 0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("restart_inj_count", 32'(inj_count_o), 1);

      // Burst with gaps in valid_i
      doReset();
      mode_i = 2'd2; err_mask_i = 2'b11;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, W'($urandom), 1'($urandom), 1'b0, 1'b0);
         if ($urandom_range(0, 2) == 0) idle();
      end
      idle();
      checkOutput("burst_inj_count", 32'(inj_count_o), 256);
      checkOutput("burst_word_count", 32'(word_count_o), 300);

      // Random mode
      doReset();
      mode_i = 2'd3; err_mask_i = 2'b11; ber_thresh_i = 8'd0;
      for (int i = 0; i < 1000; i++) applyStimulus(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("rand_thresh0_inj", 32'(inj_count_o), 0);
      doReset();
      ber_thresh_i = 8'hE2;
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("lfsr_seed_word", 32'(data_o), 3);
      ber_thresh_i = 8'hC3;
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      idle();
      checkOutput("lfsr_step1_word", 32'(data_o), 0);
      ber_thresh_i = 8'hFF;
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
      idle();

      // Reference FIFO: decoder returns bits 40 cycles later, bit 17 inverted
      doReset();
      mode_i = 2'd0;
      for (int i = 0; i < 256; i++) refs[i] = 1'($urandom);
      for (int t = 0; t < 296; t++) begin
         applyStimulus(t < 256, W'($urandom), (t < 256) ? refs[t % 256] : 1'b0,
                       t >= 40, (t >= 40) ? (refs[(t - 40) % 256] ^ (t == 57)) : 1'b0);
      end
      idle();
      checkOutput("fifo_dec_err", 32'(dec_err_count_o), 1);
      checkOutput("fifo_done", 32'(done_o), 1);
      checkOutput("fifo_no_overflow", 32'(overflow_o), 0);
      checkOutput("fifo_no_underflow", 32'(underflow_o), 0);

      // Boundaries
      doReset();
      for (int i = 0; i < 65; i++) applyStimulus(1'b1, '0, 1'b1, 1'b0, 1'b0);
      idle();
      checkOutput("overflow_set", 32'(overflow_o), 1);
      doReset();
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
      idle();
      checkOutput("underflow_set", 32'(underflow_o), 1);
      doReset();
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0);
      idle();
      checkOutput("full_pushpop_ovf", 32'(overflow_o), 0);
      checkOutput("full_pushpop_unf", 32'(underflow_o), 0);

      // Randomised mixed traffic
      doReset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) mode_i = 2'($urandom);
         if ($urandom_range(0, 49) == 0) err_mask_i = W'($urandom);
         if ($urandom_range(0, 49) == 0) ber_thresh_i = 8'($urandom);
         valid_i = ($urandom_range(0, 3) != 0);
         data_i = W'($urandom);
         ref_bit_i = 1'($urandom);
         dec_valid_i = ($urandom_range(0, 3) < 3);
         dec_bit_i = 1'($urandom);
      end
      @(negedge clk);
      rst = 1'b0;
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
